// File: rtl/output_port_tx_pkg.sv
// Shared router definitions: flit typing, transmit FSM states
// and default link sizing used by both ends of a router link.
package output_port_tx_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int DEPTH_DEF      = 5;
  localparam int FLIT_TYPE_MSB  = DATA_WIDTH_DEF - 1;
  localparam int FLIT_TYPE_LSB  = DATA_WIDTH_DEF - 2;

  typedef enum logic [1:0] {
    FLIT_BODY      = 2'b00,
    FLIT_HEAD      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_t;

  typedef enum logic {
    TX_IDLE   = 1'b0,
    TX_ACTIVE = 1'b1
  } tx_state_t;

  // Legal flit types for the current wormhole state.
  function automatic logic proto_ok(
    input tx_state_t  s,
    input flit_type_t t
  );
    if (s == TX_IDLE)
      return (t == FLIT_HEAD) || (t == FLIT_HEAD_TAIL);
    return (t == FLIT_BODY) || (t == FLIT_TAIL);
  endfunction

endpackage

// File: rtl/output_port_tx_credit_counter.sv
// Free-slot counter for the downstream buffer: up/down,
// saturating at DEPTH, sticky flag on an excess credit return.
module output_port_tx_credit_counter #(
  parameter int DEPTH     = 5,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 err_o
);

  localparam logic [CNT_WIDTH-1:0] MAX = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case ({dec_i, inc_i})
      2'b10: cnt_d = cnt_q - ONE;
      2'b01: begin
        if (cnt_q == MAX) err_d = 1'b1;
        else              cnt_d = cnt_q + ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= MAX;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign count_o = cnt_q;
  assign err_o   = err_q;

endmodule

// File: rtl/output_port_tx.sv
// Router output port, transmit side: 2-entry staging FIFO,
// credit-gated send and wormhole packet tracking.
module output_port_tx
  import output_port_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  tx_write_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  input  logic                  credit_i,
  output logic [CNT_WIDTH-1:0]  credits_o,
  output logic                  locked_o,
  output logic                  credit_err_o,
  output logic                  proto_err_o
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;

  logic                  tx_write_q, tx_write_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  tx_state_t             state_q, state_d;
  logic                  proto_err_q, proto_err_d;

  logic                  full, empty, push, send;
  logic [DATA_WIDTH-1:0] head;
  flit_type_t            head_type;
  logic [CNT_WIDTH-1:0]  credits;

  assign full      = (cnt_q == 2'd2);
  assign empty     = (cnt_q == 2'd0);
  assign push      = in_valid_i & ~full;
  assign send      = ~empty & (credits != '0);
  assign head      = mem_q[rd_ptr_q];
  assign head_type = flit_type_t'(head[DATA_WIDTH-1 -: 2]);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (send) rd_ptr_d = ~rd_ptr_q;
    unique case ({push, send})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: ;
    endcase
  end

  // Illegal flits are flagged but still forwarded untouched.
  always_comb begin
    tx_write_d  = send;
    tx_data_d   = send ? head : tx_data_q;
    state_d     = state_q;
    proto_err_d = proto_err_q;
    if (send) begin
      if (!proto_ok(state_q, head_type)) proto_err_d = 1'b1;
      unique case (1'b1)
        (state_q == TX_IDLE) && (head_type == FLIT_HEAD):
          state_d = TX_ACTIVE;
        (state_q == TX_ACTIVE) && (head_type == FLIT_TAIL):
          state_d = TX_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      tx_write_q  <= 1'b0;
      tx_data_q   <= '0;
      state_q     <= TX_IDLE;
      proto_err_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      tx_write_q  <= tx_write_d;
      tx_data_q   <= tx_data_d;
      state_q     <= state_d;
      proto_err_q <= proto_err_d;
    end
  end

  output_port_tx_credit_counter #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_credit (
    .clk     (clk),
    .reset   (reset),
    .dec_i   (send),
    .inc_i   (credit_i),
    .count_o (credits),
    .err_o   (credit_err_o)
  );

  assign in_ready_o  = ~full;
  assign tx_write_o  = tx_write_q;
  assign tx_data_o   = tx_data_q;
  assign credits_o   = credits;
  assign locked_o    = (state_q == TX_ACTIVE);
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_output_port_tx.sv
// Bench for output_port_tx: directed phases plus random traffic
// against a queue-based model of the link behaviour.
module tb_output_port_tx;

  localparam int DW    = 16;
  localparam int DEPTH = 5;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid_i;
  logic [DW-1:0] in_data_i;
  logic          in_ready_o;
  logic          tx_write_o;
  logic [DW-1:0] tx_data_o;
  logic          credit_i;
  logic [CW-1:0] credits_o;
  logic          locked_o;
  logic          credit_err_o;
  logic          proto_err_o;

  output_port_tx #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .tx_write_o   (tx_write_o),
    .tx_data_o    (tx_data_o),
    .credit_i     (credit_i),
    .credits_o    (credits_o),
    .locked_o     (locked_o),
    .credit_err_o (credit_err_o),
    .proto_err_o  (proto_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_q[$];
  int            m_cred;
  bit            m_open, m_perr, m_cerr, m_wr, m_pushed;
  logic [DW-1:0] m_data;
  int            wr_cnt;
  logic [DW-1:0] last_wr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cred = DEPTH;
    m_open = 0;
    m_perr = 0;
    m_cerr = 0;
    m_wr   = 0;
    m_data = '0;
  endtask

  task automatic apply_type(input logic [1:0] t);
    case (t)
      2'b01: if (m_open) m_perr = 1; else m_open = 1;
      2'b00: if (!m_open) m_perr = 1;
      2'b10: if (!m_open) m_perr = 1; else m_open = 0;
      default: if (m_open) m_perr = 1;
    endcase
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".ready"}, 32'(in_ready_o), 32'(m_q.size() < 2));
    chk({ph, ".write"}, 32'(tx_write_o), 32'(m_wr));
    chk({ph, ".data"}, 32'(tx_data_o), 32'(m_data));
    chk({ph, ".credits"}, 32'(credits_o), 32'(m_cred));
    chk({ph, ".locked"}, 32'(locked_o), 32'(m_open));
    chk({ph, ".cerr"}, 32'(credit_err_o), 32'(m_cerr));
    chk({ph, ".perr"}, 32'(proto_err_o), 32'(m_perr));
  endtask

  // One clock: predict from the link rules, clock, then compare.
  task automatic cycle(input string ph);
    bit            send, push;
    logic [DW-1:0] f;
    send = (m_q.size() > 0) && (m_cred > 0);
    push = in_valid_i && (m_q.size() < 2);
    m_pushed = push;
    if (send) begin
      f = m_q.pop_front();
      m_data = f;
      apply_type(f[15:14]);
      if (!credit_i) m_cred--;
    end else if (credit_i) begin
      if (m_cred == DEPTH) m_cerr = 1;
      else                 m_cred++;
    end
    m_wr = send;
    if (push) m_q.push_back(in_data_i);
    @(posedge clk);
    #1;
    check_all(ph);
    if (tx_write_o) begin
      wr_cnt++;
      last_wr = tx_data_o;
    end
  endtask

  task automatic restore(input string ph);
    in_valid_i = 0;
    for (int i = 0; i < 16; i++) begin
      if (m_cred == DEPTH && m_q.size() == 0) break;
      credit_i = (m_cred < DEPTH);
      cycle(ph);
    end
    credit_i = 0;
    chk({ph, ".full_credits"}, 32'(credits_o), 32'(DEPTH));
  endtask

  function automatic logic [DW-1:0] flit2(input int i);
    if (i == 0) return 16'h4000;
    if (i == 6) return 16'h8006;
    if (i == 7) return 16'h4007;
    return 16'(i);
  endfunction

  initial begin
    int idx;
    logic [DW-1:0] seq5 [3];
    seq5 = '{16'h4001, 16'h0002, 16'h8003};

    reset      = 0;
    in_valid_i = 1;
    in_data_i  = 16'h4abc;
    credit_i   = 0;
    wr_cnt     = 0;
    last_wr    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("t1_reset");
    reset = 1;
    in_valid_i = 0;
    cycle("t1_idle");

    // Fill until credits run out.
    wr_cnt = 0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid_i = (idx < 8);
      in_data_i  = flit2(idx);
      cycle("t2");
      if (m_pushed) idx++;
    end
    chk("t2.writes", 32'(wr_cnt), 32'd5);
    chk("t2.credits", 32'(credits_o), 32'd0);
    chk("t2.ready", 32'(in_ready_o), 32'd0);
    in_valid_i = 0;
    repeat (2) cycle("t2_hold");
    chk("t2.no_more", 32'(wr_cnt), 32'd5);

    wr_cnt = 0;
    credit_i = 1;
    cycle("t3");
    credit_i = 0;
    repeat (3) cycle("t3");
    chk("t3.writes", 32'(wr_cnt), 32'd1);
    chk("t3.flit6", 32'(last_wr), 32'h0005);
    chk("t3.credits", 32'(credits_o), 32'd0);
    restore("t3_restore");

    idx = 0;
    for (int c = 0; c < 30 && m_cred > 3; c++) begin
      in_valid_i = 1;
      in_data_i  = 16'hC000 | 16'(idx);
      credit_i   = 0;
      cycle("t4_ramp");
      if (m_pushed) idx++;
    end
    wr_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid_i = 1;
      in_data_i  = 16'hC000 | 16'(idx);
      credit_i   = 1;
      cycle("t4");
      if (m_pushed) idx++;
      chk("t4.credits3", 32'(credits_o), 32'd3);
    end
    chk("t4.throughput", 32'(wr_cnt), 32'd12);
    credit_i = 0;
    restore("t4_restore");

    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1;
      in_data_i  = seq5[i];
      cycle("t5");
    end
    in_valid_i = 0;
    repeat (3) cycle("t5_drain");
    chk("t5.perr_clean", 32'(proto_err_o), 32'd0);
    chk("t5.unlocked", 32'(locked_o), 32'd0);
    in_valid_i = 1;
    in_data_i  = 16'h0004;
    cycle("t5_bad");
    in_valid_i = 0;
    cycle("t5_bad");
    chk("t5.bad_sent", 32'(tx_write_o), 32'd1);
    chk("t5.bad_data", 32'(tx_data_o), 32'h0004);
    chk("t5.perr", 32'(proto_err_o), 32'd1);
    restore("t5_restore");

    for (int c = 0; c < 300; c++) begin
      in_valid_i = 1'($urandom_range(0, 1));
      in_data_i  = 16'($urandom);
      credit_i   = (m_cred < DEPTH) && ($urandom_range(0, 3) != 0);
      cycle("rand");
    end
    credit_i = 0;
    restore("rand_restore");

    credit_i = 1;
    cycle("t6_excess");
    credit_i = 0;
    cycle("t6_hold");
    chk("t6.cerr", 32'(credit_err_o), 32'd1);
    chk("t6.credits5", 32'(credits_o), 32'd5);
    in_valid_i = 1;
    in_data_i  = 16'h4010;
    cycle("t6_pkt");
    in_data_i  = 16'h0011;
    cycle("t6_pkt");
    in_data_i  = 16'h0012;
    cycle("t6_pkt");
    chk("t6.locked", 32'(locked_o), 32'd1);
    #2;
    reset = 0;
    #1;
    model_reset();
    check_all("t6_rst");
    @(posedge clk);
    #1;
    check_all("t6_rst_hold");
    in_valid_i = 0;
    reset = 1;
    cycle("t6_post");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
